// File: rtl/wisc_cache_pkg.sv
// Shared constants for the cache miss-fill controller: fill-state encoding,
// block geometry and the word-to-byte offset helper.
package wisc_cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFF_W           = 4;
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);
  localparam int WORD_SHIFT      = OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_GRANT = 2'b01,
    FILL       = 2'b10,
    DONE       = 2'b11
  } fill_state_e;

  // Byte offset of a word within its block.
  function automatic logic [OFF_W-1:0] word_byte_offset(input logic [IDX_W-1:0] idx);
    return {idx, {WORD_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Miss/arbiter/memory/data-array signal bundle of the fill controller.
// MISS_STALL_CNT_EN adds the stall_cycles observation counter.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  import wisc_cache_pkg::*;

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              mem_fetch;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;
  logic              cache_busy;
  logic              cache_finished;
  logic              mem_enable;
  logic [ADDR_W-1:0] mem_address;
  logic              data_wen;
  logic [IDX_W-1:0]  data_word_sel;
  logic [DATA_W-1:0] data_out;
  logic              tag_wen;
  logic [ADDR_W-1:0] fill_block_addr;
`ifdef MISS_STALL_CNT_EN
  logic [15:0]       stall_cycles;
`endif

  modport master (
    input  miss_detected, miss_address, mem_fetch, memory_data_valid, memory_data,
    output cache_busy, cache_finished, mem_enable, mem_address, data_wen,
    output data_word_sel, data_out, tag_wen, fill_block_addr
`ifdef MISS_STALL_CNT_EN
    , output stall_cycles
`endif
  );

  modport slave (
    output miss_detected, miss_address, mem_fetch, memory_data_valid, memory_data,
    input  cache_busy, cache_finished, mem_enable, mem_address, data_wen,
    input  data_word_sel, data_out, tag_wen, fill_block_addr
`ifdef MISS_STALL_CNT_EN
    , input stall_cycles
`endif
  );

endinterface

// File: rtl/cache_fill_ctrl_fill_word_counter.sv
// Word index counter for the fill engine: increment enable, synchronous
// clear (priority over increment) and a last-word terminal flag.
module fill_word_counter
  import wisc_cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] cnt,
  output logic             terminal
);

  logic [IDX_W-1:0] cnt_r;

  // Counter state: clear wins over increment, wraps naturally past the last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {IDX_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {IDX_W{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_r + IDX_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt      = cnt_r;
  assign terminal = (cnt_r == {IDX_W{1'b1}});

endmodule

// File: rtl/cache_fill_ctrl.sv
// Per-cache miss-fill controller: requests the memory grant, streams the block
// reads, writes returned words and the tag. Optional macro: MISS_STALL_CNT_EN.
module cache_fill_ctrl
  import wisc_cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  cache_fill_ctrl_if.master  bus
);

  fill_state_e       state_r;
  logic [ADDR_W-1:0] fill_block_addr_r;
  logic              issue_done_r;
  logic [IDX_W-1:0]  issue_cnt_s;
  logic [IDX_W-1:0]  rcv_cnt_s;
  logic              issue_term_s;
  logic              rcv_term_s;
  logic              cnt_clr_s;
  logic              mem_enable_s;
  logic              accept_s;
  logic              last_word_s;

  // Both counters sit at zero whenever no fill is running.
  assign cnt_clr_s = (state_r != FILL);

  fill_word_counter u_issue_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .inc      (mem_enable_s),
    .cnt      (issue_cnt_s),
    .terminal (issue_term_s)
  );

  fill_word_counter u_rcv_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .inc      (accept_s),
    .cnt      (rcv_cnt_s),
    .terminal (rcv_term_s)
  );

  // Issue/return qualification; returns outside FILL belong to the other cache.
  always_comb begin
    mem_enable_s = 1'b0;
    accept_s     = 1'b0;
    last_word_s  = 1'b0;
    if (state_r == FILL) begin
      mem_enable_s = bus.mem_fetch && !issue_done_r;
      accept_s     = bus.memory_data_valid;
      last_word_s  = bus.memory_data_valid && rcv_term_s;
    end else begin
      mem_enable_s = 1'b0;
      accept_s     = 1'b0;
      last_word_s  = 1'b0;
    end
  end

  // Fill sequencing, block-base latch and the issue-saturation flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r           <= IDLE;
      fill_block_addr_r <= {ADDR_W{1'b0}};
      issue_done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.miss_detected) begin
            fill_block_addr_r <= {bus.miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state_r           <= WAIT_GRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_GRANT: begin
          issue_done_r <= 1'b0;
          if (bus.mem_fetch) begin
            state_r <= FILL;
          end else begin
            state_r <= WAIT_GRANT;
          end
        end
        FILL: begin
          if (mem_enable_s && issue_term_s) begin
            issue_done_r <= 1'b1;
          end else begin
            issue_done_r <= issue_done_r;
          end
          if (last_word_s) begin
            state_r <= DONE;
          end else begin
            state_r <= FILL;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.cache_busy      = (state_r != IDLE);
  assign bus.cache_finished  = (state_r == DONE);
  assign bus.mem_enable      = mem_enable_s;
  // Base is block-aligned, so the word offset add never carries out.
  assign bus.mem_address     = mem_enable_s
                               ? (fill_block_addr_r + ADDR_W'(word_byte_offset(issue_cnt_s)))
                               : {ADDR_W{1'b0}};
  assign bus.data_wen        = accept_s;
  assign bus.data_word_sel   = accept_s ? rcv_cnt_s : {IDX_W{1'b0}};
  assign bus.data_out        = accept_s ? bus.memory_data : {DATA_W{1'b0}};
  assign bus.tag_wen         = last_word_s;
  assign bus.fill_block_addr = fill_block_addr_r;

`ifdef MISS_STALL_CNT_EN
  logic [15:0] stall_cycles_r;

  // Saturating count of busy cycles since reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= 16'h0000;
    end else if ((state_r != IDLE) && (stall_cycles_r != 16'hFFFF)) begin
      stall_cycles_r <= stall_cycles_r + 16'h0001;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign bus.stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed self-checking bench for cache_fill_ctrl with a 4-cycle pipelined
// memory responder and a cycle-indexed expectation model.
module tb_cache_fill_ctrl;
  import wisc_cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic        busy;
    logic        fin;
    logic        men;
    logic [15:0] addr;
    logic        wen;
    logic [2:0]  sel;
    logic [15:0] dout;
    logic        tag;
    logic [15:0] fba;
  } obs_t;

  int          checks = 0;
  int          passed = 0;
  logic        pipe_v [4];
  logic [15:0] pipe_a [4];
  logic [15:0] last_fba;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = bus.cache_busy;
    o.fin  = bus.cache_finished;
    o.men  = bus.mem_enable;
    o.addr = bus.mem_address;
    o.wen  = bus.data_wen;
    o.sel  = bus.data_word_sel;
    o.dout = bus.data_out;
    o.tag  = bus.tag_wen;
    o.fba  = bus.fill_block_addr;
    return o;
  endfunction

  function automatic int req_cycle(input int k, input int d, input int gap_k, input int gap_len);
    return 2 + d + k + ((k >= gap_k) ? gap_len : 0);
  endfunction

  // Expected outputs in cycle n of a fill whose miss is in cycle 0.
  function automatic obs_t expect_fill(input int n, input int d, input int gap_k, input int gap_len,
                                       input logic [15:0] maddr, input logic [15:0] prev_fba);
    obs_t        e;
    int          tag_c;
    logic [15:0] base;
    e     = '0;
    base  = {maddr[15:4], 4'h0};
    tag_c = req_cycle(7, d, gap_k, gap_len) + 4;
    e.busy = (n >= 1) && (n <= tag_c + 1);
    e.fin  = (n == tag_c + 1);
    e.tag  = (n == tag_c);
    e.fba  = (n >= 1) ? base : prev_fba;
    for (int k = 0; k < 8; k++) begin
      if (req_cycle(k, d, gap_k, gap_len) == n) begin
        e.men  = 1'b1;
        e.addr = base + 16'(2 * k);
      end
      if (req_cycle(k, d, gap_k, gap_len) + 4 == n) begin
        e.wen  = 1'b1;
        e.sel  = 3'(k);
        e.dout = mem_word(base + 16'(2 * k));
      end
    end
    return e;
  endfunction

  task automatic drive(input logic miss, input logic [15:0] maddr, input logic fetch,
                       input logic xvalid, input logic [15:0] xdata);
    bus.miss_detected = miss;
    bus.miss_address  = maddr;
    bus.mem_fetch     = fetch;
    if (pipe_v[3] === 1'b1) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = mem_word(pipe_a[3]);
    end else if (xvalid) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = xdata;
    end else begin
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'h0000;
    end
    #2;
  endtask

  task automatic advance();
    for (int i = 3; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = bus.mem_enable;
    pipe_a[0] = bus.mem_address;
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input string name, input logic [15:0] maddr, input logic [15:0] alt_addr,
                          input int d, input int gap_k, input int gap_len, input int ncycles,
                          input logic hold_miss, input logic noise);
    obs_t e;
    obs_t o;
    logic fetch;
    for (int n = 0; n < ncycles; n++) begin
      fetch = (n >= 1 + d) &&
              !((gap_len > 0) && (n >= 2 + d + gap_k) && (n < 2 + d + gap_k + gap_len));
      drive((n == 0) || hold_miss, (n == 0) ? maddr : alt_addr, fetch,
            noise && (n <= 1 + d), 16'hDEAD);
      e = expect_fill(n, d, gap_k, gap_len, maddr, last_fba);
      o = sample();
      checks++;
      if (o !== e) $display("FAIL %s cycle %0d: observed %h required %h", name, n, o, e);
      else passed++;
      advance();
    end
    last_fba = {maddr[15:4], 4'h0};
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    o = sample();
    checks++;
    if (o !== obs_t'(0)) $display("FAIL reset_state: observed %h required 0", o);
    else passed++;
    advance();
    drive(1'b1, 16'h1234, 1'b1, 1'b1, 16'h1111);
    o = sample();
    checks++;
    if (o !== obs_t'(0)) $display("FAIL reset_held: observed %h required 0", o);
    else passed++;
    advance();
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    advance();
    o = sample();
    checks++;
    if (o !== obs_t'(0)) $display("FAIL reset_idle: observed %h required 0", o);
    else passed++;
`ifdef MISS_STALL_CNT_EN
    checks++;
    if (bus.stall_cycles !== 16'h0000) $display("FAIL reset_stall: observed %h required 0", bus.stall_cycles);
    else passed++;
`endif
    last_fba = 16'h0000;
  endtask

  task automatic test_nominal();
    run_fill("nominal", 16'h1234, 16'h0000, 0, 8, 0, 16, 1'b0, 1'b0);
  endtask

  task automatic test_grant_wait();
    run_fill("grant_wait", 16'h4A5F, 16'h0000, 5, 8, 0, 21, 1'b0, 1'b0);
  endtask

  task automatic test_grant_drop();
    run_fill("grant_drop", 16'h1234, 16'h0000, 0, 3, 2, 18, 1'b0, 1'b0);
  endtask

  task automatic test_stray_valid();
    obs_t o;
    obs_t e;
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    e     = '0;
    e.fba = last_fba;
    o     = sample();
    checks++;
    if (o !== e) $display("FAIL stray_idle: observed %h required %h", o, e);
    else passed++;
    advance();
    run_fill("stray_valid", 16'h0C0C, 16'h0000, 2, 8, 0, 17, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    obs_t o;
    run_fill("pre_reset", 16'h1234, 16'h0000, 0, 8, 0, 10, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    rst = 1'b0;
    #1;
    o = sample();
    checks++;
    if (o !== obs_t'(0)) $display("FAIL reset_async: observed %h required 0", o);
    else passed++;
    advance();
    rst = 1'b1;
    for (int n = 11; n <= 13; n++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      o = sample();
      checks++;
      if (o !== obs_t'(0)) $display("FAIL late_return cycle %0d: observed %h required 0", n, o);
      else passed++;
      advance();
    end
    last_fba = 16'h0000;
    run_fill("refill", 16'h2FFE, 16'h0000, 0, 8, 0, 16, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_fill("b2b_first", 16'h1234, 16'h5678, 0, 8, 0, 15, 1'b1, 1'b0);
    run_fill("b2b_second", 16'h5678, 16'h0000, 0, 8, 0, 16, 1'b0, 1'b0);
  endtask

`ifdef MISS_STALL_CNT_EN
  task automatic test_stall_count();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    advance();
    rst = 1'b1;
    last_fba = 16'h0000;
    run_fill("stall_first", 16'h1234, 16'h1234, 0, 8, 0, 15, 1'b1, 1'b0);
    run_fill("stall_second", 16'h1234, 16'h0000, 0, 8, 0, 16, 1'b0, 1'b0);
    checks++;
    if (bus.stall_cycles !== 16'd28) $display("FAIL stall_cycles: observed %0d required 28", bus.stall_cycles);
    else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = 16'h0000;
    end
    last_fba = 16'h0000;
    test_reset();
    test_nominal();
    test_grant_wait();
    test_grant_drop();
    test_stray_valid();
    test_reset_mid_fill();
    test_back_to_back();
`ifdef MISS_STALL_CNT_EN
    test_stall_count();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
